// File: rtl/inst_encode_if.sv
// ============================================================================
// Module  : inst_encode_if
// Purpose : Handshake bus between a micro-op producer and the encoder FIFO.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface inst_encode_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [5:0]               in_name;
  logic [4:0]               in_rd;
  logic [4:0]               in_rs1;
  logic [4:0]               in_rs2;
  logic [31:0]              in_imm;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_inst;
  logic                     out_err;
  logic [$clog2(DEPTH):0]   count;
  logic [CNT_W-1:0]         err_cnt;

  modport master (
    output flush, in_valid, in_name, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_err, count, err_cnt
  );

  modport slave (
    input  flush, in_valid, in_name, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_err, count, err_cnt
  );
endinterface

`default_nettype wire

// File: rtl/inst_encode.sv
// ============================================================================
// Module  : inst_encode
// Purpose : RV32I micro-op to instruction-word encoder with output FIFO.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_encode #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic          clk_in,
  input  logic          rst_in,
  inst_encode_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [5:0] c_op_add   = 6'd1;
  localparam logic [5:0] c_op_sub   = 6'd2;
  localparam logic [5:0] c_op_lw    = 6'd3;
  localparam logic [5:0] c_op_sw    = 6'd4;
  localparam logic [5:0] c_op_beq   = 6'd5;
  localparam logic [5:0] c_op_lui   = 6'd6;
  localparam logic [5:0] c_op_auipc = 6'd7;
  localparam logic [5:0] c_op_jal   = 6'd8;
  localparam logic [5:0] c_op_jalr  = 6'd9;

  localparam logic [31:0]    c_nop   = 32'h0000_0013;
  localparam logic [PTR_W:0] c_depth = (PTR_W+1)'(DEPTH);

  logic [31:0] r_mem_inst [DEPTH];
  logic        r_mem_err  [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [CNT_W-1:0] r_err_cnt;

  logic [31:0] w_word;
  logic [31:0] w_inst;
  logic        w_legal;
  logic        w_imm_i_ok;
  logic        w_imm_b_ok;
  logic        w_imm_j_ok;
  logic        w_imm_u_ok;
  logic        w_out_valid;
  logic        w_pop;
  logic        w_push;
  logic        w_in_ready;

  logic [31:0] w_imm;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;

  assign w_imm = bus.in_imm;
  assign w_rd  = bus.in_rd;
  assign w_rs1 = bus.in_rs1;
  assign w_rs2 = bus.in_rs2;

  // Immediate must be reproducible from the bits the format actually stores.
  assign w_imm_i_ok = (&w_imm[31:11]) | ~(|w_imm[31:11]);
  assign w_imm_b_ok = ~w_imm[0] & ((&w_imm[31:12]) | ~(|w_imm[31:12]));
  assign w_imm_j_ok = ~w_imm[0] & ((&w_imm[31:20]) | ~(|w_imm[31:20]));
  assign w_imm_u_ok = ~(|w_imm[11:0]);

  always_comb begin
    w_word  = c_nop;
    w_legal = 1'b0;
    case (bus.in_name)
      c_op_add: begin
        w_word  = {7'b0000000, w_rs2, w_rs1, 3'b000, w_rd, 7'b0110011};
        w_legal = 1'b1;
      end
      c_op_sub: begin
        w_word  = {7'b0100000, w_rs2, w_rs1, 3'b000, w_rd, 7'b0110011};
        w_legal = 1'b1;
      end
      c_op_lw: begin
        w_word  = {w_imm[11:0], w_rs1, 3'b010, w_rd, 7'b0000011};
        w_legal = w_imm_i_ok;
      end
      c_op_jalr: begin
        w_word  = {w_imm[11:0], w_rs1, 3'b000, w_rd, 7'b1100111};
        w_legal = w_imm_i_ok;
      end
      c_op_sw: begin
        w_word  = {w_imm[11:5], w_rs2, w_rs1, 3'b010, w_imm[4:0], 7'b0100011};
        w_legal = w_imm_i_ok;
      end
      c_op_beq: begin
        w_word  = {w_imm[12], w_imm[10:5], w_rs2, w_rs1, 3'b000,
                   w_imm[4:1], w_imm[11], 7'b1100011};
        w_legal = w_imm_b_ok;
      end
      c_op_lui: begin
        w_word  = {w_imm[31:12], w_rd, 7'b0110111};
        w_legal = w_imm_u_ok;
      end
      c_op_auipc: begin
        w_word  = {w_imm[31:12], w_rd, 7'b0010111};
        w_legal = w_imm_u_ok;
      end
      c_op_jal: begin
        w_word  = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], w_rd, 7'b1101111};
        w_legal = w_imm_j_ok;
      end
      default: begin
        w_word  = c_nop;
        w_legal = 1'b0;
      end
    endcase
  end

  assign w_inst = w_legal ? w_word : c_nop;

  assign w_out_valid = (r_count != '0);
  assign w_pop       = w_out_valid && bus.out_ready;
  assign w_in_ready  = (r_count < c_depth) || w_pop;
  assign w_push      = bus.in_valid && w_in_ready;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_inst[i] <= '0;
        r_mem_err[i]  <= 1'b0;
      end
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem_inst[r_wr_ptr] <= w_inst;
        r_mem_err[r_wr_ptr]  <= ~w_legal;
        r_wr_ptr             <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A flushed accept is dropped, so it must not be counted either.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_err_cnt <= '0;
    end else if (!bus.flush && w_push && !w_legal && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_inst  = r_mem_inst[r_rd_ptr];
  assign bus.out_err   = r_mem_err[r_rd_ptr];
  assign bus.count     = r_count;
  assign bus.err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_inst_encode.sv
// ============================================================================
// Module  : tb_inst_encode
// Purpose : Directed scoreboard bench for the inst_encode encoder FIFO.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_inst_encode;

  localparam logic [5:0] c_add   = 6'd1;
  localparam logic [5:0] c_sub   = 6'd2;
  localparam logic [5:0] c_lw    = 6'd3;
  localparam logic [5:0] c_sw    = 6'd4;
  localparam logic [5:0] c_beq   = 6'd5;
  localparam logic [5:0] c_lui   = 6'd6;
  localparam logic [5:0] c_auipc = 6'd7;
  localparam logic [5:0] c_jal   = 6'd8;
  localparam logic [5:0] c_jalr  = 6'd9;
  localparam logic [31:0] c_nop  = 32'h0000_0013;

  logic clk_in = 1'b0;
  logic rst_in;

  inst_encode_if #(.DEPTH(4), .CNT_W(16)) bus ();

  inst_encode #(.DEPTH(4), .CNT_W(16)) u_dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int exp_errs = 0;
  logic [32:0] sb [$];
  logic [32:0] cur_exp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Handshake is sampled at the falling edge; outputs popped there are scored.
  task automatic cycle();
    logic [32:0] e;
    @(negedge clk_in);
    if (bus.flush) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        check("sb_avail", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("out_inst", 64'(bus.out_inst), 64'(e[31:0]));
          check("out_err", 64'(bus.out_err), 64'(e[32]));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(cur_exp);
        if (cur_exp[32]) exp_errs++;
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [5:0] nm, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm,
                       input logic [31:0] exp_inst, input logic exp_err);
    bus.in_valid = 1'b1;
    bus.in_name  = nm;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = imm;
    cur_exp      = {exp_err, exp_inst};
    cycle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drive_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    drive(c_add, rd, rs1, rs2, 32'd0, {7'b0, rs2, rs1, 3'b000, rd, 7'h33}, 1'b0);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_out_inst"},  64'(bus.out_inst),  64'd0);
    check({tag, "_out_err"},   64'(bus.out_err),   64'd0);
    check({tag, "_count"},     64'(bus.count),     64'd0);
    check({tag, "_err_cnt"},   64'(bus.err_cnt),   64'd0);
    check({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
  endtask

  initial begin
    rst_in        = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_name   = '0;
    bus.in_rd     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_imm    = '0;
    bus.out_ready = 1'b0;
    cur_exp       = '0;
    repeat (2) @(posedge clk_in);
    #1;
    check_reset_values("reset");
    rst_in = 1'b0;

    // Streaming legal encodings, consumer always ready.
    bus.out_ready = 1'b1;
    drive(c_add, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0);
    check("latency_out_valid", 64'(bus.out_valid), 64'd1);
    check("latency_out_inst", 64'(bus.out_inst), 64'h002081B3);
    drive(c_sw,    5'd0,  5'd2, 5'd5, 32'hFFFFFFFC, 32'hFE512E23, 1'b0);
    drive(c_lui,   5'd10, 5'd7, 5'd9, 32'h12345000, 32'h12345537, 1'b0);
    drive(c_jal,   5'd1,  5'd3, 5'd4, 32'h00000800, 32'h001000EF, 1'b0);
    drive(c_sub,   5'd3,  5'd1, 5'd2, 32'd0,        32'h402081B3, 1'b0);
    drive(c_lw,    5'd4,  5'd2, 5'd0, 32'd8,        32'h00812203, 1'b0);
    drive(c_jalr,  5'd1,  5'd5, 5'd0, 32'hFFFFFFFF, 32'hFFF280E7, 1'b0);
    drive(c_beq,   5'd0,  5'd1, 5'd2, 32'hFFFFFFFE, 32'hFE208FE3, 1'b0);
    drive(c_auipc, 5'd5,  5'd0, 5'd0, 32'hFFFFF000, 32'hFFFFF297, 1'b0);
    drive(c_jal,   5'd0,  5'd0, 5'd0, 32'hFFF00000, 32'h8000006F, 1'b0);

    // Illegal immediates and an unknown name become flagged NOPs.
    drive(c_beq, 5'd0, 5'd1, 5'd2, 32'd3,        c_nop, 1'b1);
    drive(c_lw,  5'd4, 5'd2, 5'd0, 32'h00000800, c_nop, 1'b1);
    idle(1);
    check("err_cnt_two", 64'(bus.err_cnt), 64'd2);
    drive(6'h3F, 5'd1, 5'd1, 5'd1, 32'd0,        c_nop, 1'b1);
    drive(c_jal, 5'd1, 5'd0, 5'd0, 32'h00100000, c_nop, 1'b1);
    drive(c_lui, 5'd1, 5'd0, 5'd0, 32'h00000001, c_nop, 1'b1);
    idle(1);
    check("err_cnt_model", 64'(bus.err_cnt), 64'(exp_errs));

    // Fill to DEPTH, then simultaneous push/pop while full.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive_add(5'(i + 1), 5'(i + 6), 5'(i + 11));
    check("full_count", 64'(bus.count), 64'd4);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    drive_add(5'd31, 5'd31, 5'd31);
    check("full_no_accept", 64'(bus.count), 64'd4);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_add(5'(i + 20), 5'(i + 2), 5'(i + 25));
      check("pushpop_count", 64'(bus.count), 64'd4);
    end
    idle(4);
    check("drained_count", 64'(bus.count), 64'd0);

    // Flush with a concurrent (illegal) accept drops it without counting.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive_add(5'(i + 7), 5'd1, 5'd2);
    check("pre_flush_count", 64'(bus.count), 64'd3);
    bus.flush = 1'b1;
    drive(c_beq, 5'd0, 5'd0, 5'd0, 32'd3, c_nop, 1'b1);
    bus.flush = 1'b0;
    check("flush_count", 64'(bus.count), 64'd0);
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_err_cnt", 64'(bus.err_cnt), 64'(exp_errs));

    // Asynchronous reset in the middle of the stream.
    drive_add(5'd9, 5'd8, 5'd7);
    drive(c_lw, 5'd1, 5'd1, 5'd1, 32'h00000800, c_nop, 1'b1);
    rst_in = 1'b1;
    #1;
    check_reset_values("async_rst");
    sb.delete();
    exp_errs = 0;
    #1;
    rst_in = 1'b0;
    bus.out_ready = 1'b1;
    drive(c_add, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0);
    check("post_rst_count", 64'(bus.count), 64'd1);
    idle(2);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
